// File: rtl/mips_exec_mem_stage.sv
// Execute/memory slice of a single-cycle MIPS datapath: control decode, 32-bit ALU,
// word-addressed data memory and write-back/branch selection. Only memory writes are clocked.
module mips_exec_mem_stage #(
  parameter int DM_DEPTH  = 64,
  parameter int DM_ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] mem_rdata,
  output logic        pcsrc,
  output logic [31:0] branch_off
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] imm;
  logic        regdst, alusrc, memread, memwrite, memtoreg, branch, dec_reg_write;
  logic [2:0]  aluop;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] rdata_raw;
  logic [DM_ADDR_W-1:0] dm_idx;
  logic [31:0] dmem [DM_DEPTH];

  // The register-file read addresses are consumed outside this slice.
  logic unused_rs_field;
  assign unused_rs_field = ^inst[25:21];

  assign op         = inst[31:26];
  assign funct      = inst[5:0];
  assign imm        = {{16{inst[15]}}, inst[15:0]};
  assign branch_off = {imm[29:0], 2'b00};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    regdst        = 1'b0;
    alusrc        = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    memtoreg      = 1'b0;
    branch        = 1'b0;
    dec_reg_write = 1'b0;
    aluop         = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin
        regdst        = 1'b1;
        dec_reg_write = 1'b1;
        unique case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: dec_reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        alusrc        = 1'b1;
        memread       = 1'b1;
        memtoreg      = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        aluop  = ALU_SUB;
        branch = 1'b1;
      end
      OP_ADDI: begin
        alusrc        = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b = alusrc ? imm : rt_data;

  always_comb begin
    alu_y = rs_data + alu_b;
    unique case (aluop)
      ALU_SUB: alu_y = rs_data - alu_b;
      ALU_AND: alu_y = rs_data & alu_b;
      ALU_OR:  alu_y = rs_data | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default: alu_y = rs_data + alu_b;
    endcase
  end

  // Misaligned and out-of-range addresses fold onto a word slot.
  assign dm_idx    = alu_y[DM_ADDR_W+1:2];
  assign rdata_raw = dmem[dm_idx];

  // NOTE: the memory is built from resettable flops because reset must clear every word at once;
  // a RAM macro could not do this, so this array must stay small.
  // NOTE: sequential state uses non-blocking assignments so reads in the same edge see old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_DEPTH; i++) dmem[i] <= '0;
    end else if (memwrite) begin
      dmem[dm_idx] <= rt_data;
    end
  end

  // Reset overrides the combinational outputs immediately, not at the next edge.
  assign alu_result = reset ? alu_y : '0;
  assign zero       = (alu_result == '0);
  assign reg_write  = reset & dec_reg_write;
  assign pcsrc      = reset & branch & zero;
  assign mem_rdata  = (reset && memread) ? rdata_raw : '0;
  assign write_data = memtoreg ? mem_rdata : alu_result;
  assign write_reg  = regdst ? inst[15:11] : inst[20:16];

endmodule

// File: tb/tb_mips_exec_mem_stage.sv
// Randomized scoreboard bench for mips_exec_mem_stage: a driver pushes expected responses
// from an instruction-level model, a monitor pops and compares once per cycle.
module tb_mips_exec_mem_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = '0, rs_data = '0, rt_data = '0;
  logic [31:0] alu_result, write_data, mem_rdata, branch_off;
  logic        zero, reg_write, pcsrc;
  logic [4:0]  write_reg;

  mips_exec_mem_stage #(.DM_DEPTH(DEPTH), .DM_ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .inst(inst), .rs_data(rs_data), .rt_data(rt_data),
    .alu_result(alu_result), .zero(zero), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_rdata(mem_rdata), .pcsrc(pcsrc), .branch_off(branch_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        in_reset;
    logic        chk_alu;
    logic [31:0] alu;
    logic        zero;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        pcsrc;
    logic [31:0] boff;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          driver_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  // Instruction-level reference: what each opcode means architecturally.
  function automatic exp_t predict(input string tag, input logic [31:0] i,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic rst_n_v);
    exp_t e;
    logic [31:0] simm;
    logic        from_mem;
    simm = {{16{i[15]}}, i[15:0]};
    e.tag = tag; e.in_reset = !rst_n_v; e.chk_alu = 1'b1;
    e.alu = a + b; e.rw = 0; e.wreg = 0; e.rdata = 0; e.pcsrc = 0;
    e.boff = simm * 4;
    from_mem = 0;
    case (i[31:26])
      6'h00: begin
        e.wreg = i[15:11];
        e.rw   = 1;
        case (i[5:0])
          6'h20: e.alu = a + b;
          6'h22: e.alu = a - b;
          6'h24: e.alu = a & b;
          6'h25: e.alu = a | b;
          6'h2A: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e.rw = 0; e.chk_alu = 0; end
        endcase
      end
      6'h23: begin
        e.alu = a + simm; e.rw = 1; e.wreg = i[20:16];
        e.rdata = model_mem[word_of(e.alu)]; from_mem = 1;
      end
      6'h2B: e.alu = a + simm;
      6'h04: begin e.alu = a - b; e.pcsrc = (a == b); end
      6'h08: begin e.alu = a + simm; e.rw = 1; e.wreg = i[20:16]; end
      default: e.alu = a + b;
    endcase
    if (!rst_n_v) begin
      e.alu = 0; e.chk_alu = 1; e.rw = 0; e.pcsrc = 0; e.rdata = 0; from_mem = 0;
    end
    e.zero  = (e.alu == 0);
    e.wdata = from_mem ? e.rdata : e.alu;
    return e;
  endfunction

  // One instruction per cycle: applied just after the rising edge, checked at the falling edge.
  task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic rst_n_v = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    inst = i; rs_data = a; rt_data = b; reset = rst_n_v;
    if (!rst_n_v) for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    e = predict(tag, i, a, b, rst_n_v);
    sb_q.push_back(e);
    if (rst_n_v && i[31:26] == 6'h2B)
      model_mem[word_of(a + {{16{i[15]}}, i[15:0]})] = b;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk_alu) check({e.tag, ".alu_result"}, alu_result, e.alu);
        check({e.tag, ".zero"},       {31'd0, zero},      {31'd0, e.zero});
        check({e.tag, ".reg_write"},  {31'd0, reg_write}, {31'd0, e.rw});
        check({e.tag, ".pcsrc"},      {31'd0, pcsrc},     {31'd0, e.pcsrc});
        check({e.tag, ".mem_rdata"},  mem_rdata,          e.rdata);
        if (e.chk_alu) check({e.tag, ".write_data"}, write_data, e.wdata);
        if (e.rw) check({e.tag, ".write_reg"}, {27'd0, write_reg}, {27'd0, e.wreg});
        if (!e.in_reset) check({e.tag, ".branch_off"}, branch_off, e.boff);
      end
    end
  end

  initial begin : driver
    logic [5:0]  op, fn;
    logic [5:0]  ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F, 6'h11};
    logic [5:0]  fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h13};
    logic [31:0] a, b, i;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;

    // Seed a word, then reset with a store decoded and the clock running.
    issue("seed_sw", itype(6'h2B, 5'd2, 16'h0004), 32'h10, 32'h1234_5678);
    issue("rst_sw0", itype(6'h2B, 5'd2, 16'h0004), 32'h10, 32'hAAAA_5555, 1'b0);
    issue("rst_sw1", itype(6'h2B, 5'd2, 16'h0008), 32'h10, 32'h5555_AAAA, 1'b0);
    issue("rst_sw2", itype(6'h2B, 5'd2, 16'h0000), 32'h0,  32'hFFFF_FFFF, 1'b0);
    issue("post_rst_lw14", itype(6'h23, 5'd3, 16'h0004), 32'h10, 32'h0);
    issue("post_rst_lw18", itype(6'h23, 5'd3, 16'h0008), 32'h10, 32'h0);

    issue("add", rtype(5'd9, 6'h20), 32'd5, 32'd7);
    issue("sub", rtype(5'd10, 6'h22), 32'd5, 32'd7);
    issue("slt", rtype(5'd11, 6'h2A), 32'hFFFF_FFFF, 32'd1);
    issue("and", rtype(5'd12, 6'h24), 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue("or",  rtype(5'd13, 6'h25), 32'hF0F0_F0F0, 32'h0F00_0F00);
    issue("addi_neg", itype(6'h08, 5'd4, 16'hFFFE), 32'd1, 32'd0);

    issue("sw_beef", itype(6'h2B, 5'd2, 16'h0004), 32'h10, 32'hDEAD_BEEF);
    issue("lw_beef", itype(6'h23, 5'd5, 16'h0004), 32'h10, 32'h0);

    issue("beq_taken", itype(6'h04, 5'd2, 16'hFFFF), 32'd3, 32'd3);
    issue("beq_not",   itype(6'h04, 5'd2, 16'hFFFF), 32'd3, 32'd4);

    issue("sw_wrap", itype(6'h2B, 5'd2, 16'h0003), 32'h100, 32'hCAFE_F00D);
    issue("lw_word0", itype(6'h23, 5'd6, 16'h0000), 32'h0, 32'h0);
    issue("sw_top", itype(6'h2B, 5'd2, 16'h00FC), 32'h0, 32'h0BAD_CAFE);
    issue("lw_top_alias", itype(6'h23, 5'd6, 16'h01FC), 32'h0, 32'h0);

    issue("undef_op", {6'h3F, 26'h0_1234}, 32'h0000_0014, 32'h7777_7777);
    issue("undef_fn", rtype(5'd7, 6'h00), 32'h0000_0014, 32'h7777_7777);
    issue("lw_after_undef", itype(6'h23, 5'd6, 16'h0004), 32'h10, 32'h0);

    // Reset again after traffic: previously written words must read 0.
    issue("rst_mid", itype(6'h23, 5'd6, 16'h0004), 32'h10, 32'h0, 1'b0);
    issue("lw_cleared", itype(6'h23, 5'd6, 16'h0004), 32'h10, 32'h0);
    issue("lw0_cleared", itype(6'h23, 5'd6, 16'h0000), 32'h0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      i  = {op, 20'($urandom), fn};
      if (op == 6'h23 || op == 6'h2B) i[15:0] = 16'($urandom_range(0, 64)) - 16'd8;
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      b  = $urandom;
      if (op == 6'h04 && $urandom_range(0, 1) == 1) b = a;
      issue("rand", i, a, b, ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1);
    end

    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
